instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 109 ++++++++++
 tb/tb_instruction_fetch.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: PC, one-outstanding-request memory handshake and instruction register.
// Optional ack timeout with sticky fetch_err is compiled in when FETCH_TIMEOUT_EN is defined.
module instruction_fetch #(
  parameter int PC_W    = 8,
  parameter int TMO_CYC = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_target,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [15:0]     mem_rdata,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [6:0]      opcode,
  output logic [2:0]      dr,
  output logic [2:0]      sa,
  output logic [2:0]      sb,
  output logic [5:0]      IM,
  output logic            CS,
  output logic [PC_W-1:0] pc,
  output logic            fetch_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] VALID = 2'd2;

  // The timeout counter is 4 bits wide, so the limit must fit in it.
  if (TMO_CYC < 1 || TMO_CYC > 15) begin : g_bad_tmo
    $error("TMO_CYC must be in 1..15");
  end

  logic [1:0]  state, state_nxt;
  logic [15:0] ir;
  logic        fetch_enter;
  logic        fetch_done;
  logic        timeout;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = FETCH;
      FETCH:   if (mem_ack) state_nxt = VALID;
               else if (timeout) state_nxt = IDLE;
      VALID:   if (dec_ready) state_nxt = run ? FETCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign fetch_enter = (state != FETCH) && (state_nxt == FETCH);
  assign fetch_done  = (state == FETCH) && mem_ack;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= '0;
      mem_addr <= '0;
      ir       <= 16'h0000;
    end else begin
      state <= state_nxt;
      // A redirect wins over the post-fetch increment.
      if (pc_load)         pc <= pc_target;
      else if (fetch_done) pc <= pc + 1'b1;
      // The request address is captured only on entry, so a redirect mid-fetch waits for the next request.
      if (fetch_enter)     mem_addr <= pc;
      if (fetch_done)      ir <= mem_rdata;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] tmo_cnt;
  logic       err_q;

  assign timeout = (state == FETCH) && !mem_ack && (tmo_cnt == 4'(TMO_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      if (fetch_enter)                      tmo_cnt <= 4'd0;
      else if (state == FETCH && !mem_ack)  tmo_cnt <= tmo_cnt + 4'd1;
      if (timeout)                          err_q   <= 1'b1;
    end
  end

  assign fetch_err = err_q;
`else
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  assign mem_req   = (state == FETCH);
  assign dec_valid = (state == VALID);

  assign opcode = ir[15:9];
  assign dr     = ir[8:6];
  assign sa     = ir[5:3];
  assign sb     = ir[2:0];
  assign IM     = ir[5:0];
  assign CS     = (ir[15:14] == 2'b11);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_instruction_fetch;

  localparam int PC_W    = 8;
  localparam int TMO_CYC = 15;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            run, pc_load, mem_ack, dec_ready;
  logic [PC_W-1:0] pc_target;
  logic [15:0]     mem_rdata;
  logic            mem_req, dec_valid, CS, fetch_err;
  logic [PC_W-1:0] mem_addr, pc;
  logic [6:0]      opcode;
  logic [2:0]      dr, sa, sb;
  logic [5:0]      IM;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: "waiting for memory" / "holding an instruction" plus architectural values.
  bit          m_fetch, m_hold, m_err;
  int          m_pc, m_addr, m_wait;
  logic [15:0] m_ir;

  instruction_fetch #(.PC_W(PC_W), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .pc_load(pc_load), .pc_target(pc_target),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .opcode(opcode), .dr(dr), .sa(sa),
    .sb(sb), .IM(IM), .CS(CS), .pc(pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fetch = 0; m_hold = 0; m_err = 0;
    m_pc = 0; m_addr = 0; m_wait = 0; m_ir = 16'h0000;
  endtask

  task automatic compare_all();
    check("mem_req",   32'(mem_req),   32'(m_fetch));
    check("dec_valid", 32'(dec_valid), 32'(m_hold));
    check("mem_addr",  32'(mem_addr),  32'(m_addr));
    check("pc",        32'(pc),        32'(m_pc));
    check("opcode",    32'(opcode),    32'(m_ir >> 9));
    check("dr",        32'(dr),        32'((m_ir >> 6) & 16'h7));
    check("sa",        32'(sa),        32'((m_ir >> 3) & 16'h7));
    check("sb",        32'(sb),        32'(m_ir & 16'h7));
    check("IM",        32'(IM),        32'(m_ir & 16'h3F));
    check("CS",        32'(CS),        32'((m_ir >> 14) == 16'h3));
    check("fetch_err", 32'(fetch_err), 32'(m_err));
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input bit r, input bit ld, input int tgt, input bit ack,
                      input logic [15:0] rd, input bit rdy);
    bit was_fetch, was_hold;
    run = r; pc_load = ld; pc_target = PC_W'(tgt);
    mem_ack = ack; mem_rdata = rd; dec_ready = rdy;
    @(posedge clk);
    was_fetch = m_fetch;
    was_hold  = m_hold;
    if (!was_fetch && !was_hold) begin
      if (r) begin m_fetch = 1; m_addr = m_pc; m_wait = 0; end
    end else if (was_fetch) begin
      if (ack) begin
        m_ir = rd; m_pc = (m_pc + 1) % (1 << PC_W);
        m_fetch = 0; m_hold = 1;
      end else begin
`ifdef FETCH_TIMEOUT_EN
        m_wait++;
        if (m_wait == TMO_CYC) begin m_err = 1; m_fetch = 0; end
`endif
      end
    end else if (rdy) begin
      m_hold = 0;
      if (r) begin m_fetch = 1; m_addr = m_pc; m_wait = 0; end
    end
    if (ld) m_pc = tgt % (1 << PC_W);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    run = 0; pc_load = 0; pc_target = '0; mem_ack = 0; mem_rdata = '0; dec_ready = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    do_reset();

    // First fetch after reset, ack two cycles after the request.
    step(1, 0, 0, 0, 16'h0, 0);
    check("first_addr", 32'(mem_addr), 32'h0);
    check("first_req",  32'(mem_req),  32'h1);
    step(1, 0, 0, 0, 16'h0, 0);
    step(1, 0, 0, 1, 16'hC7FB, 0);
    check("c7fb_opcode", 32'(opcode),    32'h63);
    check("c7fb_IM",     32'(IM),        32'h3B);
    check("c7fb_CS",     32'(CS),        32'h1);
    check("c7fb_valid",  32'(dec_valid), 32'h1);
    check("c7fb_pc",     32'(pc),        32'h1);

    // Downstream stall: everything must hold.
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 16'h0, 0);
      check("stall_opcode", 32'(opcode),  32'h63);
      check("stall_req",    32'(mem_req), 32'h0);
    end

    // Redirect to the top address, then fetch across the wrap.
    step(1, 1, 8'hFF, 0, 16'h0, 0);
    step(1, 0, 0, 0, 16'h0, 1);
    check("wrap_addr", 32'(mem_addr), 32'hFF);
    step(1, 0, 0, 1, 16'h1234, 0);
    check("wrap_pc", 32'(pc), 32'h00);

    // Redirect coinciding with the ack.
    step(1, 0, 0, 0, 16'h0, 1);
    step(1, 1, 8'h40, 1, 16'hABCD, 0);
    check("redir_pc", 32'(pc),     32'h40);
    check("redir_op", 32'(opcode), 32'h55);
    step(1, 0, 0, 0, 16'h0, 1);
    check("redir_addr", 32'(mem_addr), 32'h40);

    // run dropped during a fetch: finish, deliver, then go idle.
    step(0, 0, 0, 0, 16'h0, 0);
    step(0, 0, 0, 1, 16'h5A5A, 0);
    check("norun_valid", 32'(dec_valid), 32'h1);
    step(0, 0, 0, 0, 16'h0, 1);
    check("norun_idle", 32'(mem_req), 32'h0);

    // Reset in the middle of a fetch.
    step(1, 0, 0, 0, 16'h0, 0);
    step(1, 0, 0, 0, 16'h0, 0);
    rst_n = 1'b0;
    #1;
    check("rst_req",   32'(mem_req),   32'h0);
    check("rst_valid", 32'(dec_valid), 32'h0);
    do_reset();
    step(1, 0, 0, 0, 16'h0, 0);
    check("post_rst_addr", 32'(mem_addr), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 8,
           $urandom_range(0, 7) == 0,
           int'($urandom_range(0, 255)),
           m_fetch && ($urandom_range(0, 9) < 4),
           16'($urandom),
           $urandom_range(0, 9) < 6);
    end

`ifdef FETCH_TIMEOUT_EN
    do_reset();
    step(0, 1, 8'h22, 0, 16'h0, 0);
    step(1, 0, 0, 0, 16'h0, 0);
    for (int i = 0; i < TMO_CYC; i++) step(0, 0, 0, 0, 16'h0, 0);
    check("tmo_err", 32'(fetch_err), 32'h1);
    check("tmo_req", 32'(mem_req),   32'h0);
    check("tmo_pc",  32'(pc),        32'h22);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
